piso_serializer: RTL and testbench

Parallel-in/serial-out stage that feeds the SIPO deserializer in the multiplier datapath. It accepts WIDTH-bit operand words over a valid/ready handshake and buffers one pending word behind the word being shifted. It emits the words one bit per cycle with first/last framing, so the downstream SIPO can reassemble them into operands. Back-to-back words stream with no idle cycle between frames.

---
 rtl/piso_serializer.sv | 158 +++++++++++++++
 tb/tb_piso_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out stage feeding the operand SIPO.
// Accepts WIDTH-bit words over load_valid/load_ready, buffers one pending
// word in a holding register and emits one bit per cycle with first/last
// framing. Back-to-back words stream with no idle cycle between frames.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_valid/ready    parallel word handshake, load_data is the word
//   data_out            current serial bit
//   out_valid/ready     serial handshake (out_ready=1 for a plain SIPO)
//   out_first/out_last  frame markers on the first / final bit
//   busy                shifter or holding register occupied
//
// Build option: define PISO_PARITY_EN to append an even-parity bit to every
// frame (frames become WIDTH+1 bits, out_last marks the parity bit).
module piso_serializer #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic active;
    logic last_bit;
    logic fire;
    logic accept;
    logic data_bit;

    // Outputs are forced quiet while rst is high, not only after the edge.
    assign active = (state_q != S_IDLE) && !rst;

`ifdef PISO_PARITY_EN
    assign last_bit = (state_q == S_PARITY);
    assign data_bit = (state_q == S_PARITY) ? par_q
                    : (LSB_FIRST ? sh_q[0] : sh_q[WIDTH-1]);
`else
    assign last_bit = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
    assign data_bit = LSB_FIRST ? sh_q[0] : sh_q[WIDTH-1];
`endif

    assign fire   = active && out_ready;
    assign accept = load_valid && load_ready;

    assign out_valid  = active;
    assign data_out   = active && data_bit;
    assign out_first  = active && (state_q == S_SHIFT) && (cnt_q == '0);
    assign out_last   = active && last_bit;
    assign load_ready = !hold_full_q && !rst;
    assign busy       = ((state_q != S_IDLE) || hold_full_q) && !rst;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
`ifdef PISO_PARITY_EN
        par_d       = par_q;
`endif

        if (fire) begin
            sh_d  = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
            cnt_d = cnt_q + CW'(1);
`ifdef PISO_PARITY_EN
            if ((state_q == S_SHIFT) && (cnt_q == CNT_LAST)) begin
                state_d = S_PARITY;
            end
`endif
        end

        if (fire && last_bit) begin
            // Frame ends this edge: held word wins over a fresh load.
            if (hold_full_q) begin
                sh_d        = hold_q;
                hold_full_d = 1'b0;
                cnt_d       = '0;
                state_d     = S_SHIFT;
`ifdef PISO_PARITY_EN
                par_d       = ^hold_q;
`endif
            end else if (accept) begin
                sh_d    = load_data;
                cnt_d   = '0;
                state_d = S_SHIFT;
`ifdef PISO_PARITY_EN
                par_d   = ^load_data;
`endif
            end else begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        end else if (accept) begin
            if (state_q == S_IDLE) begin
                sh_d    = load_data;
                cnt_d   = '0;
                state_d = S_SHIFT;
`ifdef PISO_PARITY_EN
                par_d   = ^load_data;
`endif
            end else begin
                hold_d      = load_data;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
`ifdef PISO_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
`ifdef PISO_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed self-checking bench for piso_serializer
// (WIDTH=16, LSB first), immediate assertions at every comparison point.
module tb_piso_serializer;

    localparam int W = 16;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_data;
    logic         data_out;
    logic         out_valid;
    logic         out_ready;
    logic         out_first;
    logic         out_last;
    logic         busy;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    piso_serializer #(
        .WIDTH(W),
        .LSB_FIRST(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data(load_data),
        .data_out(data_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_first(out_first),
        .out_last(out_last),
        .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected serial bit b of a frame carrying word w (LSB first).
    function automatic logic exp_bit(input logic [W-1:0] w, input int b);
        if (b < W) return w[b];
        return ^w;
    endfunction

    task automatic chk_bit(input string tag, input logic [W-1:0] w,
                           input int b);
        chk($sformatf("%s_valid[%0d]", tag, b), 32'(out_valid), 32'd1);
        chk($sformatf("%s_data[%0d]", tag, b), 32'(data_out),
            32'(exp_bit(w, b)));
        chk($sformatf("%s_first[%0d]", tag, b), 32'(out_first),
            32'(b == 0));
        chk($sformatf("%s_last[%0d]", tag, b), 32'(out_last),
            32'(b == FL - 1));
    endtask

    task automatic frame(input string tag, input logic [W-1:0] w);
        load_valid = 1'b1;
        load_data  = w;
        step();
        load_valid = 1'b0;
        for (int b = 0; b < FL; b++) begin
            chk_bit(tag, w, b);
            step();
        end
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    logic [W-1:0] words [3];
    int           t;

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        out_ready  = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_first", 32'(out_first), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_ready", 32'(load_ready), 32'd1);
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Single word: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
        frame("single", 16'hA5C3);
        frame("p0007", 16'h0007);

        // Back-to-back: second word offered the cycle after the first.
        words[0]   = 16'h0001;
        words[1]   = 16'h8000;
        load_valid = 1'b1;
        load_data  = words[0];
        step();
        load_data  = words[1];
        for (int i = 0; i < 2 * FL; i++) begin
            chk_bit("b2b", words[i / FL], i % FL);
            if (i == 1)
                chk("b2b_ready_held", 32'(load_ready), 32'd0);
            if (i == FL)
                chk("b2b_ready_free", 32'(load_ready), 32'd1);
            step();
            load_valid = 1'b0;
        end
        chk("b2b_end_valid", 32'(out_valid), 32'd0);

        // Backpressure: stall 3 cycles after bit 5.
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        step();
        load_valid = 1'b0;
        t = 0;
        for (int c = 0; c < FL + 3; c++) begin
            out_ready = !(c >= 5 && c < 8);
            chk_bit("bp", 16'hFFFF, t);
            if (out_ready) t++;
            step();
        end
        out_ready = 1'b1;
        chk("bp_transfers", 32'(t), 32'(FL));
        chk("bp_end_valid", 32'(out_valid), 32'd0);

        // Hold full: three words offered while the first shifts.
        words[0]   = 16'h1234;
        words[1]   = 16'h00F0;
        words[2]   = 16'h0F00;
        load_valid = 1'b1;
        load_data  = words[0];
        step();
        for (int i = 0; i < 3 * FL; i++) begin
            load_valid = (i <= FL);
            load_data  = (i == 0) ? words[1] : words[2];
            chk($sformatf("hf_ready[%0d]", i), 32'(load_ready),
                32'((i == 0) || (i == FL) || (i >= 2 * FL)));
            chk_bit("hf", words[i / FL], i % FL);
            step();
        end
        load_valid = 1'b0;
        chk("hf_end_valid", 32'(out_valid), 32'd0);
        chk("hf_end_busy", 32'(busy), 32'd0);

        // Reset at bit 7 with the holding register full.
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        step();
        load_data  = 16'hAAAA;
        for (int i = 0; i < 6; i++) begin
            chk_bit("rm", 16'hFFFF, i);
            step();
            load_valid = 1'b0;
        end
        chk("rm_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("rm_valid", 32'(out_valid), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_ready", 32'(load_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rm_ready_rel", 32'(load_ready), 32'd1);
        for (int i = 0; i < FL + 2; i++) begin
            step();
            chk($sformatf("rm_quiet[%0d]", i),
                {29'd0, out_valid, busy, data_out}, 32'd0);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
